sdram_bist_gen: RTL

//   Synthesisable, parametrised traffic generator/checker for the sdram_cnt user port.

---
 rtl/sdram_bist_pkg.sv | 35 +++
 rtl/sdram_bist_lfsr.sv | 43 ++++
 rtl/sdram_bist_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_bist_pkg.sv
// Shared types, constants and pattern helpers for the SDRAM BIST generator.
package sdram_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_WAIT,
        ST_W_ISSUE,
        ST_W_BUSY,
        ST_R_WAIT,
        ST_R_ISSUE,
        ST_R_VALID,
        ST_DONE
    } state_t;

    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_RND = 1'b1;

    localparam logic [31:0] LFSR_TAPS = 32'h80200003;

    // One right-shifting Galois step.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

    // Sequential data word for entry index k.
    function automatic logic [31:0] seq_word(input logic [15:0] k);
        return {~k, k};
    endfunction

    // Replicate a 32-bit word so callers can truncate to any width up to 64.
    function automatic logic [63:0] rep_word(input logic [31:0] w);
        return {w, w};
    endfunction

endpackage

// File: rtl/sdram_bist_lfsr.sv
// 32-bit pattern LFSR with one saved checkpoint for replaying a group.
module sdram_bist_lfsr
    import sdram_bist_pkg::*;
(
    input  logic        tb_clk,
    input  logic        tb_rst,
    input  logic        load,
    input  logic [31:0] seed,
    input  logic        step,
    input  logic        save,
    input  logic        restore,
    output logic [31:0] state
);

    logic [31:0] saved;
    logic [31:0] state_d;

    // Next state: load wins, then restore, then a two-step advance (one entry).
    always_comb begin
        state_d = state;
        if (load) begin
            state_d = (seed == 32'd0) ? 32'd1 : seed;
        end else if (restore) begin
            state_d = saved;
        end else if (step) begin
            state_d = lfsr_step(lfsr_step(state));
        end
    end

    // State and checkpoint registers; save captures the value being loaded.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state <= 32'd1;
            saved <= 32'd1;
        end else begin
            state <= state_d;
            if (save) begin
                saved <= state_d;
            end
        end
    end

endmodule

// File: rtl/sdram_bist_gen.sv
// Write/read-back traffic generator and checker for the SDRAM controller user port.
module sdram_bist_gen
    import sdram_bist_pkg::*;
#(
    parameter int unsigned ADDR_W      = 12,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned GROUP       = 2,
    parameter int unsigned NUM_GROUPS  = 256,
    parameter int unsigned TIMEOUT     = 10000,
    parameter int unsigned STOP_ON_ERR = 1,
    parameter int unsigned ERR_CNT_W   = 16
) (
    input  logic                 tb_clk,
    input  logic                 tb_rst,
    input  logic                 start,
    input  logic                 mode,
    input  logic [31:0]          seed,
    output logic                 en,
    output logic                 we,
    output logic [ADDR_W-1:0]    addr,
    output logic [DATA_W-1:0]    wdata,
    input  logic                 rdy,
    input  logic                 valid,
    input  logic [DATA_W-1:0]    rd_data,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout,
    output logic [ERR_CNT_W-1:0] err_cnt,
    output logic [ADDR_W-1:0]    err_addr,
    output logic [DATA_W-1:0]    err_exp,
    output logic [DATA_W-1:0]    err_got
);

    localparam int unsigned IDX_W = (GROUP > 1) ? $clog2(GROUP) : 1;
    localparam int unsigned LOG_G = $clog2(GROUP);
    localparam int unsigned G_W   = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;
    localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned KW    = (ADDR_W > 16) ? ADDR_W : 16;
    localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(GROUP - 1);

    state_t            state;
    logic              mode_q;
    logic [IDX_W-1:0]  idx;
    logic [G_W-1:0]    grp;
    logic [WD_W-1:0]   wd;
    logic [31:0]       lfsr_state;
    logic [31:0]       a_word;
    logic [31:0]       d_word;
    logic [KW-1:0]     k;
    logic [ADDR_W-1:0] gen_addr;
    logic [DATA_W-1:0] gen_data;
    logic              last_idx;
    logic              last_grp;
    logic              mism;
    logic              hold;
    logic              wd_fire;
    logic              lfsr_load;
    logic              w_done;
    logic              rd_adv;

    assign last_idx  = (idx == IDX_W'(GROUP - 1));
    assign last_grp  = (grp == G_W'(NUM_GROUPS - 1));
    assign mism      = (rd_data != gen_data);
    assign wd_fire   = (wd == WD_W'(TIMEOUT - 1));
    assign lfsr_load = (state == ST_IDLE || state == ST_DONE) && start;
    assign w_done    = (state == ST_W_BUSY) && !rdy;
    assign rd_adv    = (state == ST_R_VALID) && valid && !(mism && STOP_ON_ERR != 0);
    assign hold      = ((state == ST_W_WAIT || state == ST_R_WAIT) && !rdy)
                     || (state == ST_W_BUSY && rdy)
                     || (state == ST_R_VALID && !valid);

    sdram_bist_lfsr u_lfsr (
        .tb_clk  (tb_clk),
        .tb_rst  (tb_rst),
        .load    (lfsr_load),
        .seed    (seed),
        .step    ((w_done && !last_idx) || rd_adv),
        .save    (lfsr_load || (rd_adv && last_idx)),
        .restore (w_done && last_idx),
        .state   (lfsr_state)
    );

    // Address/data for the current entry in the latched mode.
    always_comb begin
        k      = (KW'(grp) << LOG_G) | KW'(idx);
        a_word = lfsr_step(lfsr_state);
        d_word = lfsr_step(a_word);
        if (mode_q == MODE_RND) begin
            gen_addr = (ADDR_W'(a_word) & ~IDX_MASK) | (ADDR_W'(idx) & IDX_MASK);
            gen_data = DATA_W'(rep_word(d_word));
        end else begin
            gen_addr = ADDR_W'(k);
            gen_data = DATA_W'(rep_word(seq_word(k[15:0])));
        end
    end

    // Control FSM with watchdog, compare and first-error capture.
    always_ff @(posedge tb_clk or posedge tb_rst) begin
        if (tb_rst) begin
            state    <= ST_IDLE;
            mode_q   <= MODE_SEQ;
            idx      <= '0;
            grp      <= '0;
            wd       <= '0;
            en       <= 1'b0;
            we       <= 1'b0;
            addr     <= '0;
            wdata    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
            timeout  <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_exp  <= '0;
            err_got  <= '0;
        end else begin
            wd <= wd + WD_W'(1);
            if (hold && wd_fire) begin
                state   <= ST_DONE;
                wd      <= '0;
                en      <= 1'b0;
                timeout <= 1'b1;
                busy    <= 1'b0;
                done    <= 1'b1;
                pass    <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE, ST_DONE: begin
                        if (start) begin
                            state    <= ST_W_WAIT;
                            wd       <= '0;
                            mode_q   <= mode;
                            idx      <= '0;
                            grp      <= '0;
                            busy     <= 1'b1;
                            done     <= 1'b0;
                            pass     <= 1'b0;
                            timeout  <= 1'b0;
                            err_cnt  <= '0;
                            err_addr <= '0;
                            err_exp  <= '0;
                            err_got  <= '0;
                        end
                    end
                    ST_W_WAIT: begin
                        if (rdy) begin
                            state <= ST_W_ISSUE;
                            wd    <= '0;
                            en    <= 1'b1;
                            we    <= 1'b1;
                            addr  <= gen_addr;
                            wdata <= gen_data;
                        end
                    end
                    ST_W_ISSUE: begin
                        state <= ST_W_BUSY;
                        wd    <= '0;
                        en    <= 1'b0;
                    end
                    ST_W_BUSY: begin
                        if (!rdy) begin
                            wd <= '0;
                            if (last_idx) begin
                                idx   <= '0;
                                state <= ST_R_WAIT;
                            end else begin
                                idx   <= idx + IDX_W'(1);
                                state <= ST_W_WAIT;
                            end
                        end
                    end
                    ST_R_WAIT: begin
                        if (rdy) begin
                            state <= ST_R_ISSUE;
                            wd    <= '0;
                            en    <= 1'b1;
                            we    <= 1'b0;
                            addr  <= gen_addr;
                            wdata <= gen_data;
                        end
                    end
                    ST_R_ISSUE: begin
                        state <= ST_R_VALID;
                        wd    <= '0;
                        en    <= 1'b0;
                    end
                    ST_R_VALID: begin
                        if (valid) begin
                            wd <= '0;
                            if (mism) begin
                                if (err_cnt != '1) begin
                                    err_cnt <= err_cnt + ERR_CNT_W'(1);
                                end
                                if (err_cnt == '0) begin
                                    err_addr <= addr;
                                    err_exp  <= gen_data;
                                    err_got  <= rd_data;
                                end
                            end
                            if (mism && STOP_ON_ERR != 0) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                pass  <= 1'b0;
                            end else if (last_idx) begin
                                idx <= '0;
                                if (last_grp) begin
                                    state <= ST_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    pass  <= !mism && (err_cnt == '0);
                                end else begin
                                    grp   <= grp + G_W'(1);
                                    state <= ST_W_WAIT;
                                end
                            end else begin
                                idx   <= idx + IDX_W'(1);
                                state <= ST_R_WAIT;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
